// File: rtl/z_result_stage.sv
// z_result_stage: captures ALU Z, keeps HI/LO, and streams results as one or two words over a valid/ready bus.
// Optional RESULT_FLAGS_EN adds zero/negative flags registered at capture.
module z_result_stage #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clock,
    input  logic                    clear,
    input  logic                    z_in,
    input  logic                    wide_op,
    input  logic [2*DATA_WIDTH-1:0] z_data,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    out_is_high,
    output logic                    busy,
    output logic [DATA_WIDTH-1:0]   hi_reg,
    output logic [DATA_WIDTH-1:0]   lo_reg,
`ifdef RESULT_FLAGS_EN
    output logic                    flag_zero,
    output logic                    flag_neg,
`endif
    output logic                    overrun
);
    typedef enum logic [1:0] {IDLE, SEND_LO, SEND_HI} state_t;

    state_t                  state_q;
    logic [2*DATA_WIDTH-1:0] buf_q;
    logic                    wide_q, valid_q, is_high_q, ovr_q;
    logic [DATA_WIDTH-1:0]   data_q, hi_q, lo_q;
    logic                    xfer, last_beat, accept, take;

    assign xfer      = valid_q && out_ready;
    assign last_beat = xfer && ((state_q == SEND_LO && !wide_q) || state_q == SEND_HI);
    assign accept    = (state_q == IDLE) || last_beat;
    assign take      = z_in && accept;
    assign busy      = !accept;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q   <= IDLE;
            buf_q     <= '0;
            wide_q    <= 1'b0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            is_high_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            ovr_q     <= 1'b0;
        end else begin
            ovr_q <= z_in && !accept;
            if (take) begin
                state_q   <= SEND_LO;
                buf_q     <= z_data;
                wide_q    <= wide_op;
                valid_q   <= 1'b1;
                data_q    <= z_data[DATA_WIDTH-1:0];
                is_high_q <= 1'b0;
                if (wide_op) begin
                    hi_q <= z_data[2*DATA_WIDTH-1:DATA_WIDTH];
                    lo_q <= z_data[DATA_WIDTH-1:0];
                end
            end else if (xfer) begin
                if (state_q == SEND_LO && wide_q) begin
                    state_q   <= SEND_HI;
                    data_q    <= buf_q[2*DATA_WIDTH-1:DATA_WIDTH];
                    is_high_q <= 1'b1;
                end else begin
                    state_q   <= IDLE;
                    valid_q   <= 1'b0;
                    is_high_q <= 1'b0;
                end
            end
        end
    end

`ifdef RESULT_FLAGS_EN
    logic zero_q, neg_q;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
        end else if (take) begin
            zero_q <= wide_op ? (z_data == '0) : (z_data[DATA_WIDTH-1:0] == '0);
            neg_q  <= wide_op ? z_data[2*DATA_WIDTH-1] : z_data[DATA_WIDTH-1];
        end
    end

    assign flag_zero = zero_q;
    assign flag_neg  = neg_q;
`endif

    assign out_valid   = valid_q;
    assign out_data    = data_q;
    assign out_is_high = is_high_q;
    assign hi_reg      = hi_q;
    assign lo_reg      = lo_q;
    assign overrun     = ovr_q;
endmodule

// File: tb/tb_z_result_stage.sv
// tb_z_result_stage: random and directed stimulus checked against a beat-queue reference model.
module tb_z_result_stage;
    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic        z_in = 1'b0, wide_op = 1'b0, out_ready = 1'b0;
    logic [63:0] z_data = '0;
    logic        out_valid, out_is_high, busy, overrun;
    logic [31:0] out_data, hi_reg, lo_reg;
`ifdef RESULT_FLAGS_EN
    logic        flag_zero, flag_neg;
    logic        m_zero = 1'b0, m_neg = 1'b0;
`endif

    int          errors = 0;
    int          checks = 0;
    logic [32:0] mq[$];
    logic [31:0] m_hi = '0, m_lo = '0;
    logic        m_ovr = 1'b0;

    z_result_stage #(.DATA_WIDTH(32)) dut (
        .clock(clock), .clear(clear), .z_in(z_in), .wide_op(wide_op), .z_data(z_data),
        .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
        .out_is_high(out_is_high), .busy(busy), .hi_reg(hi_reg), .lo_reg(lo_reg),
`ifdef RESULT_FLAGS_EN
        .flag_zero(flag_zero), .flag_neg(flag_neg),
`endif
        .overrun(overrun)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        chk("out_valid", out_valid, mq.size() != 0);
        if (mq.size() != 0) begin
            chk("out_data", out_data, mq[0][31:0]);
            chk("out_is_high", out_is_high, mq[0][32]);
        end
        chk("hi_reg", hi_reg, m_hi);
        chk("lo_reg", lo_reg, m_lo);
        chk("overrun", overrun, m_ovr);
`ifdef RESULT_FLAGS_EN
        chk("flag_zero", flag_zero, m_zero);
        chk("flag_neg", flag_neg, m_neg);
`endif
    endtask

    // One cycle: drive at the falling edge, advance the model at the rising edge, check at the next falling edge.
    task automatic step(input logic zi, input logic w, input logic [63:0] zd, input logic rdy);
        bit xfer, acc;
        z_in = zi; wide_op = w; z_data = zd; out_ready = rdy;
        #1;
        chk("busy", busy, !(mq.size() == 0 || (mq.size() == 1 && rdy)));
        @(posedge clock);
        xfer = mq.size() != 0 && rdy;
        acc  = mq.size() == 0 || (mq.size() == 1 && xfer);
        if (xfer) void'(mq.pop_front());
        m_ovr = zi && !acc;
        if (zi && acc) begin
            mq.push_back({1'b0, zd[31:0]});
            if (w) begin
                mq.push_back({1'b1, zd[63:32]});
                m_hi = zd[63:32];
                m_lo = zd[31:0];
            end
`ifdef RESULT_FLAGS_EN
            m_zero = w ? (zd == 64'd0) : (zd[31:0] == 32'd0);
            m_neg  = w ? zd[63] : zd[31];
`endif
        end
        @(negedge clock);
        check_outputs();
    endtask

    initial begin
        repeat (2) @(negedge clock);
        check_outputs();
        chk("busy_reset", busy, 1'b0);
        clear = 1'b0;

        step(1, 0, 64'h7, 1);
        chk("narrow_data", out_data, 32'd7);
        step(0, 0, 64'h0, 1);

        step(1, 1, 64'h0000_0002_0000_0005, 1);
        chk("wide_lo", out_data, 32'd5);
        step(0, 0, 64'h0, 1);
        chk("wide_hi", out_data, 32'd2);
        step(0, 0, 64'h0, 1);

        step(1, 1, 64'h1234_5678_9ABC_DEF0, 0);
        repeat (3) step(0, 0, 64'h0, 0);
        step(0, 0, 64'h0, 1);
        step(0, 0, 64'h0, 1);

        step(1, 1, 64'hAAAA_0001_BBBB_0002, 1);
        step(0, 0, 64'h0, 1);
        step(1, 0, 64'hFFFF, 0);
        chk("overrun_pulse", overrun, 1'b1);
        step(0, 0, 64'h0, 1);
        chk("overrun_clr", overrun, 1'b0);

        step(1, 0, 64'h5, 1);
        step(1, 0, 64'h9, 1);
        chk("b2b_data", out_data, 32'd9);
        step(0, 0, 64'h0, 1);

        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 1), $urandom_range(0, 1),
                 {$urandom(), $urandom()} & ($urandom_range(0, 7) == 0 ? 64'h0 : 64'hFFFF_FFFF_FFFF_FFFF),
                 $urandom_range(0, 3) != 0);

        step(1, 1, 64'h0000_0003_0000_0004, 1);
        step(0, 0, 64'h0, 0);
        #2 clear = 1'b1;
        #1;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_hi", hi_reg, 32'd0);
        chk("rst_lo", lo_reg, 32'd0);
        mq.delete();
        m_hi = '0; m_lo = '0; m_ovr = 1'b0;
`ifdef RESULT_FLAGS_EN
        m_zero = 1'b0; m_neg = 1'b0;
`endif
        @(negedge clock);
        clear = 1'b0;
        z_in = 1'b0; out_ready = 1'b0;
        #1;
        chk("rst_busy", busy, 1'b0);
        check_outputs();
        step(1, 0, 64'h11, 1);
        step(0, 0, 64'h0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/z_result_stage.md
Name: z_result_stage

Overview:
- Result stage directly downstream of the ALU.
- Captures the ALU's 64-bit Z output on a strobe and keeps architectural HI/LO registers for multiply/divide results.
- Sequences the captured result onto the 32-bit internal bus toward the register file using a valid/ready handshake: one beat for 32-bit ops, two beats (low word, then high word) for 64-bit ops.

Parameters:
- DATA_WIDTH, 32, width of one bus word; Z is 2*DATA_WIDTH wide.

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  asynchronous, active-high reset.
- z_in  in  1  capture strobe; sample z_data/wide_op this cycle.
- wide_op  in  1  1 = 64-bit result (multiply/divide), 0 = 32-bit result.
- z_data  in  2*DATA_WIDTH  ALU Z result.
- out_ready  in  1  consumer accepts out_data this cycle.
- out_valid  out  1  out_data holds a valid beat.
- out_data  out  DATA_WIDTH  current result word.
- out_is_high  out  1  1 when the current beat is the high word.
- busy  out  1  stage cannot accept z_in this cycle.
- hi_reg  out  DATA_WIDTH  architectural HI (remainder / product upper).
- lo_reg  out  DATA_WIDTH  architectural LO (quotient / product lower).
- overrun  out  1  one-cycle pulse: z_in dropped.

Behaviour:
- Reset (clear=1, asynchronous, any state):
  - state=IDLE.
  - out_valid=0, out_data=0, out_is_high=0, busy=0, hi_reg=0, lo_reg=0, overrun=0, internal buffer=0.
  - A reset mid-transfer discards the pending beat(s); HI/LO are also cleared.
- States:
  - IDLE: out_valid=0.
  - SEND_LO: out_valid=1, out_data=buf[DATA_WIDTH-1:0], out_is_high=0.
  - SEND_HI: out_valid=1, out_data=buf[2*DATA_WIDTH-1:DATA_WIDTH], out_is_high=1.
- A transfer occurs on a rising edge when out_valid && out_ready.
- accept = (state==IDLE) || final-beat transfer this cycle. The final beat is SEND_LO with wide=0, or SEND_HI.
- busy = !accept. It is combinational from state, the stored wide flag and out_ready.
- z_in && accept:
  - buf<=z_data; stored wide<=wide_op; next state=SEND_LO.
  - If wide_op=1, also hi_reg<=z_data[63:32] and lo_reg<=z_data[31:0] on the same edge.
  - If wide_op=0, HI/LO are unchanged.
- z_in && !accept: input ignored; overrun=1 for exactly the next cycle; buffer, state and HI/LO unchanged.
- Transitions:
  - IDLE -> SEND_LO on accepted z_in.
  - SEND_LO + transfer: wide=1 -> SEND_HI; wide=0 -> IDLE, or SEND_LO if z_in accepted in the same cycle.
  - SEND_HI + transfer -> IDLE, or SEND_LO if z_in accepted in the same cycle.
  - No transfer: state and out_data held stable; out_data must not change while out_valid=1 and out_ready=0.
- Latency:
  - z_in at edge N -> out_valid=1 from cycle N+1.
  - Best-case throughput: 1 result/cycle (32-bit ops), 1 result/2 cycles (64-bit ops).
- Back-to-back: a new result captured in the final-beat cycle produces no gap in out_valid.
- out_ready while out_valid=0 is ignored.
- Widths: no arithmetic is performed; data passes through bit-exact.

Optional Feature:
- Macro RESULT_FLAGS_EN.
- Defined: adds outputs flag_zero (1 bit) and flag_neg (1 bit), registered at capture.
  - wide_op=0: flag_zero=(z_data[31:0]==0), flag_neg=z_data[31].
  - wide_op=1: flag_zero=(z_data==0), flag_neg=z_data[63].
  - Flags are held until the next accepted capture and reset to 0 on clear.
- Undefined: the ports do not exist and no flag logic is generated; all other behaviour is identical.

Test Plan:
- 32-bit result: z_in=1, wide_op=0, z_data=64'h0000_0000_0000_0007, out_ready=1 -> next cycle out_valid=1, out_data=7, out_is_high=0; following cycle out_valid=0; hi_reg/lo_reg stay 0.
- 64-bit result: z_in, wide_op=1, z_data=64'h0000_0002_0000_0005, out_ready=1 -> beats 5 (out_is_high=0) then 2 (out_is_high=1); hi_reg=2, lo_reg=5 from cycle after capture.
- Stall: 64-bit capture with out_ready=0 for 3 cycles -> out_data=lo word stable and out_valid=1 throughout; after out_ready=1, lo beat then hi beat.
- Overrun: z_in while in SEND_HI with out_ready=0, z_data=64'hFFFF -> overrun pulses 1 cycle, buffer/HI/LO unchanged, original hi beat still delivered.
- Back-to-back: z_in during final-beat transfer with z_data=64'h9 -> no out_valid gap, next beat out_data=9.
- Reset mid-transfer: clear asserted asynchronously in SEND_HI -> out_valid, hi_reg and lo_reg drop to 0 immediately; after release the stage is IDLE and busy=0.
